button_pulse_gen: RTL and testbench
===================================

// Module: button_pulse_gen
// PURPOSE
// - Upstream stage of the BCD counter: converts a raw, bouncing, asynchronous push-button into a clean
//   single-cycle `pulse` that drives the counter's `pulse` increment input, plus a debounced level.
// - Pipeline: synchronizer -> debounce FSM with cycle counter -> one-shot pulse, with optional auto-repeat.
// PARAMETERS
// - SYNC_STAGES      2        flip-flops in btn_in synchronizer chain (>=2)
// - DEBOUNCE_CYCLES  1000000  consecutive stable cycles required to accept a press/release (>=2)
// - REPEAT_DELAY     50000000 cycles in HELD before first auto-repeat pulse (AUTOREPEAT_EN only, >=1)
// - REPEAT_PERIOD    10000000 cycles between subsequent auto-repeat pulses (AUTOREPEAT_EN only, >=1)
// PORTS
// - clk        in   1  system clock; all logic on rising edge
// - rst_n      in   1  synchronous reset, active-low
// - btn_in     in   1  raw button, active-high, asynchronous to clk, may bounce
// - pulse      out  1  registered one-cycle strobe per accepted press (and per repeat if enabled)
// - btn_level  out  1  registered debounced button level
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge):
//   - sync chain=0, state=IDLE, counters=0, pulse=0, btn_level=0.
//   - Reset mid-operation abandons any debounce in progress; no pulse is emitted for it.
// - Synchronizer: btn_in shifts through SYNC_STAGES flops; `s` = last stage. FSM sees only `s`.
// - Debounce counter: width $clog2(DEBOUNCE_CYCLES); loaded to 0 on every state entry; never wraps.
// - FSM states and transitions:
//   - IDLE: btn_level=0. s=1 -> PRESS_WAIT, cnt<=0.
//   - PRESS_WAIT:
//     - s=0 -> IDLE (glitch rejected, no pulse).
//     - s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD; pulse<=1 and btn_level<=1 on that edge.
//     - else cnt++.
//   - HELD: btn_level=1. s=0 -> RELEASE_WAIT, cnt<=0.
//   - RELEASE_WAIT:
//     - s=1 -> HELD (release bounce rejected, no new pulse, btn_level stays 1).
//     - s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, btn_level<=0.
//     - else cnt++.
// - pulse timing:
//   - pulse is high for exactly one cycle per IDLE->...->HELD acceptance; otherwise 0.
//   - Latency: number clk edges from 1 at the first edge that samples btn_in=1, with btn_in held high.
//     pulse and btn_level go high after edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
//   - Release latency is identical: btn_level falls after edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
// - Button held through reset release: treated as a fresh press; a pulse follows after full latency.
// - Input toggling every cycle never reaches HELD; no pulse, btn_level=0.
// CONFIGURATION
// - Macro AUTOREPEAT_EN defined:
//   - Repeat counter width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)); cleared on HELD entry.
//   - While in HELD (not RELEASE_WAIT), extra one-cycle pulses are emitted
//     REPEAT_DELAY cycles after the acceptance pulse, then every REPEAT_PERIOD cycles.
//   - RELEASE_WAIT freezes the repeat counter; returning to HELD resumes it; reaching IDLE clears it.
// - Macro AUTOREPEAT_EN undefined:
//   - No repeat counter is built; exactly one pulse per accepted press regardless of hold time.
// TESTING (SYNC_STAGES=2, DEBOUNCE_CYCLES=4; edge 1 = first edge sampling btn_in=1)
// - Reset: rst_n=0 for 3 edges with btn_in=0 -> pulse=0, btn_level=0 throughout.
// - Clean press: btn_in=1 for 20 cycles then 0 -> pulse high only after edge 7;
//   btn_level 1 from edge 7; btn_level 0 seven edges after the release.
// - Glitch: btn_in=1 for 3 cycles then 0 -> pulse never asserts, btn_level stays 0.
// - Release bounce: after acceptance, btn_in 0 for 2 cycles, 1 for 2, 0 for 20
//   -> total pulse count 1; btn_level stays 1 until the final stable release plus 7 edges.
// - Reset mid-press: rst_n=0 at edge 5 of a press -> pulse=0, btn_level=0;
//   with btn_in still 1, the next pulse arrives 7 edges after reset release.
// - AUTOREPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=4, btn_in held 40 cycles
//   -> pulses after edges 7, 15, 19, 23, 27, 31, 35, 39; none after release.

Source files
------------

// File: rtl/button_pulse_gen_if.sv
// button_pulse_gen_if: button-side signals between the raw push-button source and the pulse generator
// Ports (signals):
//   btn_in    raw button level, active-high, asynchronous, may bounce
//   pulse     one-cycle strobe per accepted press (and per auto-repeat when built in)
//   btn_level debounced button level
// Modports: master drives btn_in and observes the outputs; slave is the pulse generator.
interface button_pulse_gen_if;
  logic btn_in;
  logic pulse;
  logic btn_level;
  modport master(output btn_in, input pulse, input btn_level);
  modport slave(input btn_in, output pulse, output btn_level);
endinterface

// File: rtl/button_pulse_gen.sv
// button_pulse_gen: synchronizer -> debounce FSM -> one-shot pulse, optional auto-repeat (macro AUTOREPEAT_EN)
// Ports:
//   clk   system clock, rising edge
//   rst_n synchronous reset, active-low
//   bus   button_pulse_gen_if.slave: btn_in in, pulse out, btn_level out
module button_pulse_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input logic               clk,
  input logic               rst_n,
  button_pulse_gen_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pulse_q, pulse_d, level_q, level_d, rep_fire, s, done;
  assign s = sync_q[SYNC_STAGES-1];
  assign done = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
  // The counter sits at 0 unless a wait state is actively counting, so every
  // state entry sees it cleared.
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    pulse_d = 1'b0;
    level_d = level_q;
    case (state_q)
      IDLE: state_d = s ? PRESS_WAIT : IDLE;
      PRESS_WAIT: begin
        if (!s) state_d = IDLE;
        else if (done) begin
          state_d = HELD;
          pulse_d = 1'b1;
          level_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      HELD: state_d = s ? HELD : RELEASE_WAIT;
      RELEASE_WAIT: begin
        if (s) state_d = HELD;
        else if (done) begin
          state_d = IDLE;
          level_d = 1'b0;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef AUTOREPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = RMAX > 1 ? $clog2(RMAX) : 1;
  logic [RW-1:0] rc_q, rc_d;
  logic rep_q, rep_d;
  // rep_q selects the interval: first repeat after REPEAT_DELAY, then REPEAT_PERIOD.
  // Only counts while HELD with the button still down, so RELEASE_WAIT freezes it.
  always_comb begin
    rc_d = rc_q;
    rep_d = rep_q;
    rep_fire = 1'b0;
    if (state_d == IDLE || state_q == PRESS_WAIT) begin
      rc_d = '0;
      rep_d = 1'b0;
    end else if (state_q == HELD && s) begin
      rep_fire = rc_q == (rep_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1));
      rc_d = rep_fire ? '0 : rc_q + 1'b1;
      rep_d = rep_q | rep_fire;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rc_q <= '0;
      rep_q <= 1'b0;
    end else begin
      rc_q <= rc_d;
      rep_q <= rep_d;
    end
  end
`else
  logic unused_rep_cfg;
  assign unused_rep_cfg = |{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
  assign rep_fire = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      state_q <= IDLE;
      cnt_q <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn_in};
      state_q <= state_d;
      cnt_q <= cnt_d;
      pulse_q <= pulse_d | rep_fire;
      level_q <= level_d;
    end
  end
  assign bus.pulse = pulse_q;
  assign bus.btn_level = level_q;
endmodule

// File: tb/tb_button_pulse_gen.sv
// tb_button_pulse_gen: run-length model of the debounced button plus directed latency checks
module tb_button_pulse_gen;
  localparam int SYNC = 2, DEB = 4, RD = 8, RP = 4;
`ifdef AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  button_pulse_gen_if bif();
  button_pulse_gen #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
    dut (.clk(clk), .rst_n(rst_n), .bus(bif));
  always #5 clk = ~clk;
  int total = 0, bad = 0, ecount = 0, fall_e = -1;
  int pq[$];
  task automatic check(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // Model: s is btn_in delayed SYNC edges; the level flips to a value once s has
  // shown it on DEB+1 consecutive edges; repeats count held edges after acceptance.
  logic [SYNC-1:0] sh;
  logic s_m, run_val, lvl, m_pulse, prev_s, armed = 1'b0;
  int run, ticks;
  always @(posedge clk) begin
    ecount++;
    if (!rst_n) begin
      sh = '0; run = 0; run_val = 1'b0; lvl = 1'b0; m_pulse = 1'b0; ticks = 0; prev_s = 1'b0; armed = 1'b1;
    end else begin
      s_m = sh[SYNC-1];
      sh = {sh[SYNC-2:0], bif.btn_in};
      m_pulse = 1'b0;
      if (s_m == run_val) run++;
      else begin
        run_val = s_m;
        run = 1;
      end
      if (run_val != lvl && run >= DEB + 1) begin
        lvl = run_val;
        m_pulse = lvl;
        ticks = 0;
      end else if (AR && lvl && prev_s && s_m) begin
        ticks++;
        if (ticks >= RD && (ticks - RD) % RP == 0) m_pulse = 1'b1;
      end
      if (!lvl) ticks = 0;
      prev_s = s_m;
    end
  end
  logic prev_lvl = 1'b0;
  always @(negedge clk) if (armed) begin
    check("pulse", int'(bif.pulse), int'(m_pulse));
    check("btn_level", int'(bif.btn_level), int'(lvl));
    if (bif.pulse === 1'b1) pq.push_back(ecount);
    if (prev_lvl && bif.btn_level === 1'b0) fall_e = ecount;
    prev_lvl = bif.btn_level;
  end
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic int rel(int idx, int base);
    return pq.size() > idx ? pq[idx] - base : -1;
  endfunction
  int n0, base, r;
  initial begin
    bif.btn_in = 1'b0;
    cyc(3);
    check("rst_pulse", int'(bif.pulse), 0);
    check("rst_level", int'(bif.btn_level), 0);
    rst_n = 1'b1;
    cyc(5);
    n0 = pq.size(); base = ecount; fall_e = -1;
    bif.btn_in = 1'b1; cyc(20);
    bif.btn_in = 1'b0; r = ecount; cyc(15);
    check("press_latency", rel(n0, base), 7);
    check("press_count", pq.size() - n0, 1);
    check("release_latency", fall_e - r, 7);
    n0 = pq.size();
    bif.btn_in = 1'b1; cyc(3);
    bif.btn_in = 1'b0; cyc(15);
    check("glitch_count", pq.size() - n0, 0);
    check("glitch_level", int'(bif.btn_level), 0);
    n0 = pq.size(); base = ecount; fall_e = -1;
    bif.btn_in = 1'b1; cyc(12);
    bif.btn_in = 1'b0; cyc(2);
    bif.btn_in = 1'b1; cyc(2);
    bif.btn_in = 1'b0; r = ecount; cyc(20);
    check("bounce_count", pq.size() - n0, 1);
    check("bounce_latency", rel(n0, base), 7);
    check("bounce_release", fall_e - r, 7);
    n0 = pq.size();
    bif.btn_in = 1'b1; cyc(4);
    rst_n = 1'b0; cyc(2);
    check("midrst_count", pq.size() - n0, 0);
    check("midrst_level", int'(bif.btn_level), 0);
    rst_n = 1'b1; base = ecount; cyc(12);
    check("midrst_latency", rel(n0, base), 7);
    bif.btn_in = 1'b0; cyc(15);
    n0 = pq.size();
    for (int i = 0; i < 30; i++) begin
      bif.btn_in = ~bif.btn_in; cyc(1);
    end
    bif.btn_in = 1'b0; cyc(15);
    check("toggle_count", pq.size() - n0, 0);
    check("toggle_level", int'(bif.btn_level), 0);
    n0 = pq.size(); base = ecount;
    bif.btn_in = 1'b1; cyc(40);
    bif.btn_in = 1'b0; cyc(20);
`ifdef AUTOREPEAT_EN
    check("repeat_count", pq.size() - n0, 8);
    for (int k = 0; k < 8; k++) check("repeat_edge", rel(n0 + k, base), k == 0 ? 7 : 11 + 4 * k);
`else
    check("hold_count", pq.size() - n0, 1);
    check("hold_latency", rel(n0, base), 7);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
